// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module : id_ex_stage_pkg
// Shared ALU function codes, datapath widths and the ID/EX register bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int SHAMT_W  = 5;
  localparam int ALUFUN_W = 6;

  localparam logic [ALUFUN_W-1:0] ALU_ADD   = 6'b000000;
  localparam logic [ALUFUN_W-1:0] ALU_SUB   = 6'b000001;
  localparam logic [ALUFUN_W-1:0] ALU_AND   = 6'b011000;
  localparam logic [ALUFUN_W-1:0] ALU_OR    = 6'b011110;
  localparam logic [ALUFUN_W-1:0] ALU_XOR   = 6'b010110;
  localparam logic [ALUFUN_W-1:0] ALU_NOR   = 6'b010001;
  localparam logic [ALUFUN_W-1:0] ALU_PASSA = 6'b011010;
  localparam logic [ALUFUN_W-1:0] ALU_SLL   = 6'b100000;
  localparam logic [ALUFUN_W-1:0] ALU_SRL   = 6'b100001;
  localparam logic [ALUFUN_W-1:0] ALU_SRA   = 6'b100011;
  localparam logic [ALUFUN_W-1:0] ALU_EQ    = 6'b110011;
  localparam logic [ALUFUN_W-1:0] ALU_NEQ   = 6'b110001;
  localparam logic [ALUFUN_W-1:0] ALU_LT    = 6'b110101;
  localparam logic [ALUFUN_W-1:0] ALU_LEZ   = 6'b111101;
  localparam logic [ALUFUN_W-1:0] ALU_LTZ   = 6'b111011;
  localparam logic [ALUFUN_W-1:0] ALU_GTZ   = 6'b111111;

  typedef struct packed {
    logic                valid;
    logic [REG_AW-1:0]   rs_addr;
    logic [REG_AW-1:0]   rt_addr;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm;
    logic [SHAMT_W-1:0]  shamt;
    logic                alusrc1;
    logic                alusrc2;
    logic [ALUFUN_W-1:0] alufun;
    logic                sign;
    logic [REG_AW-1:0]   wr_addr;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } ex_regs_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux_32bits.sv
// ============================================================================
// Module : fwd_mux_32bits
// Operand bypass: EX/MEM beats MEM/WB beats register-file data; $0 reads 0.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fwd_mux_32bits
  import id_ex_stage_pkg::*;
(
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_data
);

  always_comb begin
    fwd_data = rf_data;
    if (addr == '0)
      fwd_data = '0;
    else if (mem_reg_write && (mem_wr_addr == addr))
      fwd_data = mem_data;
    else if (wb_reg_write && (wb_wr_addr == addr))
      fwd_data = wb_data;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module : id_ex_stage
// ID/EX register feeding the ALU: forwarding, operand selects, load-use stall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs_addr,
  input  logic [REG_AW-1:0]   id_rt_addr,
  input  logic [DATA_W-1:0]   id_rs_data,
  input  logic [DATA_W-1:0]   id_rt_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [SHAMT_W-1:0]  id_shamt,
  input  logic                id_alusrc1,
  input  logic                id_alusrc2,
  input  logic [ALUFUN_W-1:0] id_alufun,
  input  logic                id_sign,
  input  logic [REG_AW-1:0]   id_wr_addr,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                flush,
  input  logic                mem_reg_write,
  input  logic [REG_AW-1:0]   mem_wr_addr,
  input  logic [DATA_W-1:0]   mem_alu_out,
  input  logic                wb_reg_write,
  input  logic [REG_AW-1:0]   wb_wr_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                stall,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   ex_A,
  output logic [DATA_W-1:0]   ex_B,
  output logic [ALUFUN_W-1:0] ex_alufun,
  output logic                ex_sign,
  output logic [DATA_W-1:0]   ex_store_data,
  output logic [REG_AW-1:0]   ex_wr_addr,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write
);

  ex_regs_t          ex_reg;
  ex_regs_t          id_bundle;
  logic              load_use;
  logic              capture;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    id_bundle = '{valid: id_valid, rs_addr: id_rs_addr, rt_addr: id_rt_addr,
                  rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                  shamt: id_shamt, alusrc1: id_alusrc1, alusrc2: id_alusrc2,
                  alufun: id_alufun, sign: id_sign, wr_addr: id_wr_addr,
                  reg_write: id_reg_write, mem_read: id_mem_read,
                  mem_write: id_mem_write};
  end

  // Load in EX whose result the ID instruction needs cannot be bypassed in time.
  assign load_use = ex_reg.valid && ex_reg.mem_read && id_valid && (ex_reg.wr_addr != '0) &&
                    ((id_uses_rs && (id_rs_addr == ex_reg.wr_addr)) ||
                     (id_uses_rt && (id_rt_addr == ex_reg.wr_addr)));
  assign stall   = load_use && !flush;
  assign capture = !load_use && !flush;

  // Bubbles only kill the control bits; operand data is left as it was.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_reg <= '0;
    end else if (capture) begin
      ex_reg <= id_bundle;
    end else begin
      ex_reg.valid     <= 1'b0;
      ex_reg.reg_write <= 1'b0;
      ex_reg.mem_read  <= 1'b0;
      ex_reg.mem_write <= 1'b0;
      ex_reg.alufun    <= ALU_ADD;
    end
  end

  fwd_mux_32bits u_fwd_rs (
    .addr          (ex_reg.rs_addr),
    .rf_data       (ex_reg.rs_data),
    .mem_reg_write (mem_reg_write),
    .mem_wr_addr   (mem_wr_addr),
    .mem_data      (mem_alu_out),
    .wb_reg_write  (wb_reg_write),
    .wb_wr_addr    (wb_wr_addr),
    .wb_data       (wb_data),
    .fwd_data      (fwd_rs)
  );

  fwd_mux_32bits u_fwd_rt (
    .addr          (ex_reg.rt_addr),
    .rf_data       (ex_reg.rt_data),
    .mem_reg_write (mem_reg_write),
    .mem_wr_addr   (mem_wr_addr),
    .mem_data      (mem_alu_out),
    .wb_reg_write  (wb_reg_write),
    .wb_wr_addr    (wb_wr_addr),
    .wb_data       (wb_data),
    .fwd_data      (fwd_rt)
  );

  assign ex_A          = ex_reg.alusrc1 ? {{(DATA_W-SHAMT_W){1'b0}}, ex_reg.shamt} : fwd_rs;
  assign ex_B          = ex_reg.alusrc2 ? ex_reg.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = ex_reg.valid;
  assign ex_alufun     = ex_reg.alufun;
  assign ex_sign       = ex_reg.sign;
  assign ex_wr_addr    = ex_reg.wr_addr;
  assign ex_reg_write  = ex_reg.valid && ex_reg.reg_write;
  assign ex_mem_read   = ex_reg.valid && ex_reg.mem_read;
  assign ex_mem_write  = ex_reg.valid && ex_reg.mem_write;

endmodule

`default_nettype wire
